ofb_ctrl: RTL and testbench

OFB_CTRL -- requirements
Module: ofb_ctrl

---
 rtl/ofb_ctrl.sv | 141 ++++++++++++++
 tb/tb_ofb_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ofb_ctrl.sv
// TEA-based output-feedback (OFB) stream cipher controller; encrypt and decrypt are the same operation.
// Latency: accept edge N -> GEN on edge N+1 -> out_valid visible after edge N+1; 3 cycles/block at full rate.
// Backpressure: out_valid/out_data held until out_ready; in_ready low outside READY (no input buffering).
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   key[127:0]            TEA key {k0,k1,k2,k3}, stable while a block is in flight
//   iv[63:0], iv_load     IV and its one-cycle load strobe (highest priority event)
//   in_valid/in_ready/in_data     input block handshake
//   out_valid/out_ready/out_data  output block handshake, out_data registered
//   blk_cnt[31:0]         blocks delivered since last iv_load, wraps silently
//   busy                  high while generating or holding an output

module tea_core (
    input  logic [63:0]  data_in,
    input  logic [127:0] key,
    output logic [63:0]  data_out
);
    // Fully unrolled 32-round TEA encryption; purely combinational.
    logic [31:0] v0, v1, sum;
    logic [31:0] k0, k1, k2, k3;

    always_comb begin
        k0  = key[127:96];
        k1  = key[95:64];
        k2  = key[63:32];
        k3  = key[31:0];
        v0  = data_in[63:32];
        v1  = data_in[31:0];
        sum = 32'h0;
        for (int r = 0; r < 32; r++) begin
            sum = sum + 32'h9E3779B9;
            v0  = v0 + (((v1 << 4) + k0) ^ (v1 + sum) ^ ((v1 >> 5) + k1));
            v1  = v1 + (((v0 << 4) + k2) ^ (v0 + sum) ^ ((v0 >> 5) + k3));
        end
        data_out = {v0, v1};
    end
endmodule

module ofb_ctrl (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] key,
    input  logic [63:0]  iv,
    input  logic         iv_load,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [63:0]  in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [63:0]  out_data,
    output logic [31:0]  blk_cnt,
    output logic         busy
);
    typedef enum logic [1:0] {
        S_NOIV  = 2'd0,
        S_READY = 2'd1,
        S_GEN   = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] fb_q, fb_d;
    logic [63:0] data_q, data_d;
    logic [63:0] out_data_q, out_data_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] blk_cnt_q, blk_cnt_d;
    logic [63:0] ks;

    // Keystream is a function of the feedback register and key only.
    tea_core u_tea (
        .data_in  (fb_q),
        .key      (key),
        .data_out (ks)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_NOIV;
            fb_q        <= 64'h0;
            data_q      <= 64'h0;
            out_data_q  <= 64'h0;
            out_valid_q <= 1'b0;
            blk_cnt_q   <= 32'h0;
        end else begin
            state_q     <= state_d;
            fb_q        <= fb_d;
            data_q      <= data_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            blk_cnt_q   <= blk_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        fb_d        = fb_q;
        data_d      = data_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        blk_cnt_d   = blk_cnt_q;

        if (iv_load) begin
            // Restart the stream: any handshake seen this cycle is dropped.
            fb_d        = iv;
            blk_cnt_d   = 32'h0;
            out_valid_d = 1'b0;
            state_d     = S_READY;
        end else begin
            unique case (state_q)
                S_NOIV: ;
                S_READY: begin
                    if (in_valid) begin
                        data_d  = in_data;
                        state_d = S_GEN;
                    end
                end
                S_GEN: begin
                    fb_d        = ks;
                    out_data_d  = data_q ^ ks;
                    out_valid_d = 1'b1;
                    state_d     = S_OUT;
                end
                S_OUT: begin
                    if (out_ready) begin
                        blk_cnt_d   = blk_cnt_q + 32'd1;
                        out_valid_d = 1'b0;
                        state_d     = S_READY;
                    end
                end
                default: state_d = S_NOIV;
            endcase
        end
    end

    assign in_ready  = (state_q == S_READY);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign blk_cnt   = blk_cnt_q;
    assign busy      = (state_q == S_GEN) || (state_q == S_OUT);
endmodule

// File: tb/tb_ofb_ctrl.sv
module tb_ofb_ctrl;
    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] key;
    logic [63:0]  iv;
    logic         iv_load;
    logic         in_valid;
    logic         in_ready;
    logic [63:0]  in_data;
    logic         out_valid;
    logic         out_ready;
    logic [63:0]  out_data;
    logic [31:0]  blk_cnt;
    logic         busy;

    int n_chk  = 0;
    int n_fail = 0;

    // Scoreboard model state, advanced by the monitor.
    logic [63:0] sb_q[$];
    logic [63:0] m_fb;
    logic [31:0] m_cnt;

    always #5 clk = ~clk;

    ofb_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key       (key),
        .iv        (iv),
        .iv_load   (iv_load),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .blk_cnt   (blk_cnt),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference TEA encryption.
    function automatic logic [63:0] tea_ref(input logic [63:0] blk, input logic [127:0] k);
        logic [31:0] y, z, s;
        logic [31:0] kw [4];
        kw[0] = k[127:96]; kw[1] = k[95:64]; kw[2] = k[63:32]; kw[3] = k[31:0];
        y = blk[63:32];
        z = blk[31:0];
        s = 32'h0;
        repeat (32) begin
            s = s + 32'h9E3779B9;
            y = y + (((z << 4) + kw[0]) ^ (z + s) ^ ((z >> 5) + kw[1]));
            z = z + (((y << 4) + kw[2]) ^ (y + s) ^ ((y >> 5) + kw[3]));
        end
        return {y, z};
    endfunction

    // Monitor: looks at the handshakes that the next rising edge will take.
    always @(negedge clk) begin
        logic [63:0] ksm, e;
        if (!rst_n) begin
            sb_q.delete();
            m_fb  = 64'h0;
            m_cnt = 32'h0;
        end else if (iv_load) begin
            sb_q.delete();
            m_fb  = iv;
            m_cnt = 32'h0;
        end else begin
            if (in_valid && in_ready) begin
                ksm = tea_ref(m_fb, key);
                sb_q.push_back(in_data ^ ksm);
                m_fb = ksm;
            end
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    chk("sb_unexpected_out", 64'd1, 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("sb_data", out_data, e);
                end
                chk("sb_cnt", {32'h0, blk_cnt}, {32'h0, m_cnt});
                m_cnt = m_cnt + 32'd1;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_iv(input logic [63:0] v);
        iv      = v;
        iv_load = 1'b1;
        cyc();
        iv_load = 1'b0;
    endtask

    // Returns at accept-edge + 1, with the block in GEN.
    task automatic send_in(input logic [63:0] d);
        bit ok;
        ok       = 1'b0;
        in_data  = d;
        in_valid = 1'b1;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("accept_timeout", 64'd0, 64'd1);
        cyc();
        in_valid = 1'b0;
    endtask

    // Returns at the falling edge where out_valid is first seen.
    task automatic wait_out(output logic [63:0] r);
        bit ok;
        ok = 1'b0;
        r  = 64'h0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1'b1;
                r  = out_data;
                break;
            end
        end
        if (!ok) chk("output_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] pt [4];
        logic [63:0] ct [4];
        logic [63:0] r, d, ivr, iv2, iv3, iv4, tfb, expv;

        rst_n = 1'b0; key = '0; iv = '0; iv_load = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        #12;
        chk("rst_in_ready",  {63'h0, in_ready},  64'd0);
        chk("rst_out_valid", {63'h0, out_valid}, 64'd0);
        chk("rst_out_data",  out_data, 64'd0);
        chk("rst_blk_cnt",   {32'h0, blk_cnt}, 64'd0);
        chk("rst_busy",      {63'h0, busy}, 64'd0);
        cyc();
        rst_n = 1'b1;
        cyc();

        // No IV loaded: input must be refused.
        in_valid = 1'b1;
        in_data  = 64'h1234;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("noiv_in_ready",  {63'h0, in_ready},  64'd0);
            chk("noiv_out_valid", {63'h0, out_valid}, 64'd0);
        end
        in_valid = 1'b0;
        cyc();

        // Known vector with exact per-cycle latency.
        key       = '0;
        out_ready = 1'b1;
        pulse_iv(64'h0);
        @(negedge clk);
        chk("kv_ready_after_iv", {63'h0, in_ready}, 64'd1);
        cyc();
        send_in(64'h0);
        @(negedge clk);
        chk("kv_gen_out_valid", {63'h0, out_valid}, 64'd0);
        chk("kv_gen_in_ready",  {63'h0, in_ready},  64'd0);
        chk("kv_gen_busy",      {63'h0, busy},      64'd1);
        @(negedge clk);
        chk("kv_out_valid", {63'h0, out_valid}, 64'd1);
        chk("kv_out_data",  out_data, 64'h41EA3A0A94BAA940);
        chk("kv_out_busy",  {63'h0, busy}, 64'd1);
        cyc();
        @(negedge clk);
        chk("kv_blk_cnt",    {32'h0, blk_cnt}, 64'd1);
        chk("kv_done_valid", {63'h0, out_valid}, 64'd0);
        chk("kv_done_ready", {63'h0, in_ready},  64'd1);
        cyc();

        // Round trip under random key/IV.
        key = {$urandom, $urandom, $urandom, $urandom};
        ivr = {$urandom, $urandom};
        pulse_iv(ivr);
        for (int i = 0; i < 4; i++) begin
            pt[i] = {$urandom, $urandom};
            send_in(pt[i]);
            wait_out(ct[i]);
            cyc();
        end
        @(negedge clk);
        chk("rt_enc_cnt", {32'h0, blk_cnt}, 64'd4);
        cyc();
        pulse_iv(ivr);
        for (int i = 0; i < 4; i++) begin
            send_in(ct[i]);
            wait_out(r);
            chk("rt_plain", r, pt[i]);
            cyc();
        end
        @(negedge clk);
        chk("rt_dec_cnt", {32'h0, blk_cnt}, 64'd4);
        cyc();

        // Backpressure for 10 cycles in OUT.
        tfb = ivr;
        repeat (4) tfb = tea_ref(tfb, key);
        d    = {$urandom, $urandom};
        expv = d ^ tea_ref(tfb, key);
        out_ready = 1'b0;
        send_in(d);
        wait_out(r);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_out_valid", {63'h0, out_valid}, 64'd1);
            chk("bp_out_data",  out_data, expv);
            chk("bp_in_ready",  {63'h0, in_ready}, 64'd0);
            chk("bp_blk_cnt",   {32'h0, blk_cnt}, 64'd4);
        end
        cyc();
        out_ready = 1'b1;
        cyc();
        @(negedge clk);
        chk("bp_release_cnt",   {32'h0, blk_cnt}, 64'd5);
        chk("bp_release_valid", {63'h0, out_valid}, 64'd0);
        cyc();
        @(negedge clk);
        chk("bp_single_inc", {32'h0, blk_cnt}, 64'd5);
        cyc();

        // iv_load coincident with an input handshake.
        iv2      = {$urandom, $urandom};
        in_data  = 64'hDEAD_BEEF;
        in_valid = 1'b1;
        pulse_iv(iv2);
        in_valid = 1'b0;
        @(negedge clk);
        chk("co_in_ready", {63'h0, in_ready}, 64'd1);
        chk("co_in_busy",  {63'h0, busy}, 64'd0);
        chk("co_in_cnt",   {32'h0, blk_cnt}, 64'd0);
        cyc();

        // iv_load coincident with an output handshake.
        send_in(64'h5555);
        wait_out(r);
        chk("co_first_blk", r, 64'h5555 ^ tea_ref(iv2, key));
        cyc();
        out_ready = 1'b0;
        send_in(64'h6666);
        wait_out(r);
        cyc();
        iv        = iv2;
        iv_load   = 1'b1;
        out_ready = 1'b1;
        cyc();
        iv_load = 1'b0;
        @(negedge clk);
        chk("co_out_cnt",   {32'h0, blk_cnt}, 64'd0);
        chk("co_out_valid", {63'h0, out_valid}, 64'd0);
        chk("co_out_ready", {63'h0, in_ready}, 64'd1);
        cyc();

        // Abort in GEN.
        iv3 = {$urandom, $urandom};
        send_in(64'h7777);
        pulse_iv(iv3);
        @(negedge clk);
        chk("ab_gen_valid", {63'h0, out_valid}, 64'd0);
        chk("ab_gen_cnt",   {32'h0, blk_cnt}, 64'd0);
        chk("ab_gen_ready", {63'h0, in_ready}, 64'd1);
        cyc();

        // Abort in OUT, then the next block uses the new IV.
        iv4 = {$urandom, $urandom};
        out_ready = 1'b0;
        send_in(64'h8888);
        wait_out(r);
        cyc();
        pulse_iv(iv4);
        @(negedge clk);
        chk("ab_out_valid", {63'h0, out_valid}, 64'd0);
        chk("ab_out_cnt",   {32'h0, blk_cnt}, 64'd0);
        cyc();
        out_ready = 1'b1;
        d = {$urandom, $urandom};
        send_in(d);
        wait_out(r);
        chk("ab_new_ks", r, d ^ tea_ref(iv4, key));
        cyc();

        // Counter wrap.
        force dut.blk_cnt_q = 32'hFFFF_FFFF;
        m_cnt = 32'hFFFF_FFFF;
        cyc();
        release dut.blk_cnt_q;
        @(negedge clk);
        chk("wrap_preset", {32'h0, blk_cnt}, 64'hFFFF_FFFF);
        cyc();
        send_in(64'h9999);
        wait_out(r);
        cyc();
        @(negedge clk);
        chk("wrap_cnt", {32'h0, blk_cnt}, 64'd0);
        cyc();

        // Asynchronous reset while holding an output.
        out_ready = 1'b0;
        send_in(64'hAAAA);
        wait_out(r);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_out_valid", {63'h0, out_valid}, 64'd0);
        chk("ar_out_data",  out_data, 64'd0);
        chk("ar_blk_cnt",   {32'h0, blk_cnt}, 64'd0);
        chk("ar_in_ready",  {63'h0, in_ready}, 64'd0);
        chk("ar_busy",      {63'h0, busy}, 64'd0);
        cyc();
        cyc();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 64'hBBBB;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("ar_needs_iv_ready", {63'h0, in_ready}, 64'd0);
            chk("ar_needs_iv_valid", {63'h0, out_valid}, 64'd0);
        end
        in_valid = 1'b0;
        cyc();

        chk("sb_leftover", 64'(sb_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
